// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation and result handshake bundle for alu_pipe.
// master = decode-side driver/writeback consumer, slave = the ALU.
interface alu_pipe_if #(
  parameter int DWIDTH = 16,
  parameter int IWIDTH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_func;
  logic [DWIDTH-1:0] alu_a;
  logic [DWIDTH-1:0] alu_b;
  logic [IWIDTH-1:0] alu_imm;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] alu_out;
  logic [3:0]        flags;

  modport master (
    output in_valid, alu_func, alu_a, alu_b, alu_imm, out_ready,
    input  in_ready, out_valid, alu_out, flags
  );

  modport slave (
    input  in_valid, alu_func, alu_a, alu_b, alu_imm, out_ready,
    output in_ready, out_valid, alu_out, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result and {N,Z,C,V} flags.
// Optional iterative shift-add multiplier enabled by defining ALU_MUL_EN;
// without it opcode 7 completes in one cycle with a zero result.
module alu_pipe #(
  parameter int DWIDTH = 16,
  parameter int IWIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_AND  = 3'd3,
    OP_ANDI = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_MUL  = 3'd7
  } alu_op_e;

  localparam int MSB = DWIDTH - 1;

  alu_op_e           op;
  logic              run;
  logic              idle;
  logic              accept;
  logic              out_xfer;
  logic [DWIDTH-1:0] imm_s;
  logic [DWIDTH-1:0] imm_z;
  logic [DWIDTH-1:0] addend;
  logic [DWIDTH:0]   sum_ext;
  logic [DWIDTH-1:0] diff;
  logic [DWIDTH-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        alu_flags;

  assign op    = alu_op_e'(bus.alu_func);
  assign imm_s = DWIDTH'($signed(bus.alu_imm));
  assign imm_z = DWIDTH'(bus.alu_imm);

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_e;
  localparam int CW = $clog2(DWIDTH);

  state_e              state;
  logic [CW-1:0]       cnt;
  logic [2*DWIDTH-1:0] acc;
  logic [2*DWIDTH-1:0] mcand;
  logic [DWIDTH-1:0]   mplier;
  logic [2*DWIDTH-1:0] acc_next;

  assign idle     = (state == ST_IDLE);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
  assign idle = 1'b1;
`endif

  // run keeps in_ready low while reset is held and releases it one edge later
  assign bus.in_ready = run && idle && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_xfer     = bus.out_valid && bus.out_ready;

  // single-cycle datapath: result and carry/overflow for the offered op
  always_comb begin
    addend  = (op == OP_ADDI) ? imm_s : bus.alu_b;
    sum_ext = {1'b0, bus.alu_a} + {1'b0, addend};
    diff    = bus.alu_a - bus.alu_b;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[DWIDTH];
        alu_v   = (bus.alu_a[MSB] == addend[MSB]) && (sum_ext[MSB] != bus.alu_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = bus.alu_a < bus.alu_b;
        alu_v   = (bus.alu_a[MSB] != bus.alu_b[MSB]) && (diff[MSB] != bus.alu_a[MSB]);
      end
      OP_AND:  alu_res = bus.alu_a & bus.alu_b;
      OP_ANDI: alu_res = bus.alu_a & imm_z;
      OP_OR:   alu_res = bus.alu_a | bus.alu_b;
      OP_XOR:  alu_res = bus.alu_a ^ bus.alu_b;
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_res[MSB], alu_res == '0, alu_c, alu_v};

  // control FSM and result register; a new result overrides the consume-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.alu_out   <= '0;
      bus.flags     <= '0;
`ifdef ALU_MUL_EN
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      run <= 1'b1;
      if (out_xfer) bus.out_valid <= 1'b0;
`ifdef ALU_MUL_EN
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand  <= {{DWIDTH{1'b0}}, bus.alu_a};
              mplier <= bus.alu_b;
              acc    <= '0;
              cnt    <= '0;
              state  <= ST_MUL;
            end else begin
              bus.alu_out   <= alu_res;
              bus.flags     <= alu_flags;
              bus.out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(DWIDTH - 1)) begin
            bus.alu_out   <= acc_next[MSB:0];
            bus.flags     <= {acc_next[MSB], acc_next[MSB:0] == '0,
                              |acc_next[2*DWIDTH-1:DWIDTH], 1'b0};
            bus.out_valid <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`else
      if (accept) begin
        bus.alu_out   <= alu_res;
        bus.flags     <= alu_flags;
        bus.out_valid <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (DWIDTH=16, IWIDTH=8).
// MUL scenarios are compiled when ALU_MUL_EN is defined.
module tb_alu_pipe;
  localparam int DW = 16;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.DWIDTH(DW), .IWIDTH(IW)) bus ();
  alu_pipe #(.DWIDTH(DW), .IWIDTH(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [19:0] sb_q[$];

  // reference: {flags, result} from integer arithmetic
  function automatic logic [19:0] model(input logic [2:0] f, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] imm);
    longint ua, ub, sa, sb, simm, r, sr;
    logic [15:0] res;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    simm = longint'($signed(imm));
    r = 0; sr = 0; c = 1'b0; v = 1'b0; res = '0;
    case (f)
      3'd0: begin r = ua + ub; res = r[15:0]; c = r > 65535; sr = sa + sb; v = sr > 32767 || sr < -32768; end
      3'd1: begin r = ua - ub; res = r[15:0]; c = ua < ub; sr = sa - sb; v = sr > 32767 || sr < -32768; end
      3'd2: begin r = ua + (simm & 64'hFFFF); res = r[15:0]; c = r > 65535; sr = sa + simm; v = sr > 32767 || sr < -32768; end
      3'd3: res = a & b;
      3'd4: res = a & {8'h00, imm};
      3'd5: res = a | b;
      3'd6: res = a ^ b;
      default: begin
`ifdef ALU_MUL_EN
        r = ua * ub; res = r[15:0]; c = (r >> 16) != 0;
`else
        res = '0;
`endif
      end
    endcase
    return {res[15], res == 16'h0, c, v, res};
  endfunction

  // output monitor: a transfer happens at the next posedge when valid&&ready
  always @(negedge clk) begin
    logic [19:0] exp;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got out=%h flags=%b, required no result", bus.alu_out, bus.flags);
      end else begin
        exp = sb_q.pop_front();
        if ({bus.flags, bus.alu_out} !== exp) begin
          bad++;
          $display("FAIL sb_result: got out=%h flags=%b, required out=%h flags=%b",
                   bus.alu_out, bus.flags, exp[15:0], exp[19:16]);
        end
      end
    end
  end

  // call at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high
  task automatic send_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] imm, output int waited);
    bus.in_valid = 1'b1; bus.alu_func = f; bus.alu_a = a; bus.alu_b = b; bus.alu_imm = imm;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", waited);
    end else begin
      sb_q.push_back(model(f, a, b, imm));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_func = '0; bus.alu_a = '0; bus.alu_b = '0; bus.alu_imm = '0;
    #12;
    chk("rst_in_ready", 20'(bus.in_ready), 20'h0);
    chk("rst_out_valid", 20'(bus.out_valid), 20'h0);
    chk("rst_alu_out", 20'(bus.alu_out), 20'h0);
    chk("rst_flags", 20'(bus.flags), 20'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 20'(bus.in_ready), 20'h1);
  endtask

  task automatic test_add();
    int w;
    send_op(3'd0, 16'h7FFF, 16'h0001, 8'h00, w);
    bus.in_valid = 1'b0;
    chk("add_valid", 20'(bus.out_valid), 20'h1);
    chk("add_ovf", {bus.flags, bus.alu_out}, {4'b1001, 16'h8000});
    send_op(3'd0, 16'hFFFF, 16'h0001, 8'h00, w);
    bus.in_valid = 1'b0;
    chk("add_wrap", {bus.flags, bus.alu_out}, {4'b0110, 16'h0000});
    drain();
  endtask

  task automatic test_sub_imm();
    int w;
    send_op(3'd1, 16'h0003, 16'h0005, 8'h00, w);
    chk("sub_borrow", {bus.flags, bus.alu_out}, {4'b1010, 16'hFFFE});
    send_op(3'd1, 16'h8000, 16'h0001, 8'h00, w);
    chk("sub_ovf", {bus.flags, bus.alu_out}, {4'b0001, 16'h7FFF});
    send_op(3'd2, 16'h0010, 16'h0000, 8'hFF, w);
    chk("addi_sext", {bus.flags, bus.alu_out}, {4'b0010, 16'h000F});
    send_op(3'd4, 16'hFFFF, 16'h0000, 8'hF0, w);
    chk("andi_zext", {bus.flags, bus.alu_out}, {4'b0000, 16'h00F0});
    for (int i = 0; i < 16; i++)
      send_op(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom), 8'($urandom), w);
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    bus.out_ready = 1'b0;
    send_op(3'd6, 16'hAAAA, 16'h5555, 8'h00, w);
    bus.alu_func = 3'd0; bus.alu_a = 16'h0001; bus.alu_b = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 20'(bus.in_ready), 20'h0);
      chk("bp_hold", {bus.flags, bus.alu_out}, {4'b1000, 16'hFFFF});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_op(3'd0, 16'h0001, 16'h0002, 8'h00, w);
    bus.in_valid = 1'b0;
    chk("bp_same_cycle_accept", 20'(w), 20'h0);
    chk("bp_new_result", {3'b000, bus.out_valid, bus.alu_out}, {4'b0001, 16'h0003});
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int miss = 0;
    for (int i = 0; i < 8; i++) begin
      send_op(3'd0, 16'(i * 1000 + 7), 16'(i * 3 + 1), 8'h00, w);
      if (w != 0 || bus.out_valid !== 1'b1) miss++;
    end
    bus.in_valid = 1'b0;
    chk("stream_consecutive", 20'(miss), 20'h0);
    drain();
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_one(input logic [15:0] a, input logic [15:0] b, input logic [19:0] req);
    int w;
    int busy = 0;
    send_op(3'd7, a, b, 8'h00, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy++;
    end
    @(posedge clk); #1;
    chk("mul_busy", 20'(busy), 20'h0);
    chk("mul_done_valid", 20'(bus.out_valid), 20'h1);
    chk("mul_result", {bus.flags, bus.alu_out}, req);
    drain();
  endtask

  task automatic test_mul();
    mul_one(16'h0100, 16'h0100, {4'b0110, 16'h0000});
    mul_one(16'd12, 16'd13, {4'b0000, 16'd156});
  endtask
`else
  task automatic test_mul();
    int w;
    send_op(3'd7, 16'd12, 16'd13, 8'h00, w);
    bus.in_valid = 1'b0;
    chk("op7_disabled", {bus.flags, bus.alu_out}, {4'b0100, 16'h0000});
    drain();
  endtask
`endif

  task automatic test_reset_mid_op();
    int w;
    int seen = 0;
`ifdef ALU_MUL_EN
    send_op(3'd7, 16'd12, 16'd13, 8'h00, w);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
`else
    bus.out_ready = 1'b0;
    send_op(3'd5, 16'h1234, 16'h4321, 8'h00, w);
    bus.in_valid = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    chk("mid_rst_outputs", {bus.flags, bus.alu_out}, 20'h0);
    chk("mid_rst_valid_ready", {bus.out_valid, bus.in_ready}, 20'h0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < DW + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk("mid_rst_no_result", 20'(seen), 20'h0);
    @(posedge clk); #1;
    send_op(3'd0, 16'd1, 16'd1, 8'h00, w);
    bus.in_valid = 1'b0;
    chk("post_rst_add", {3'b000, bus.out_valid, bus.alu_out}, {4'b0001, 16'd2});
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_imm();
    test_backpressure();
    test_back_to_back();
    test_mul();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
